axis_frame_len_fifo: RTL and testbench

AXIS_FRAME_LEN_FIFO -- requirements
Module: axis_frame_len_fifo

---
 rtl/axis_frame_len_pkg.sv | 21 ++
 rtl/axis_frame_len_fifo_if.sv | 35 +++
 rtl/len_sync_fifo.sv | 75 +++++++
 rtl/axis_frame_len_fifo.sv | 102 ++++++++++
 tb/tb_axis_frame_len_fifo.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/axis_frame_len_pkg.sv
// Shared constants and helpers for the frame-length monitor FIFO.
package axis_frame_len_pkg;

  // Bit positions inside the 2-bit length tuser field.
  localparam int LEN_USER_BAD      = 0;
  localparam int LEN_USER_OVERSIZE = 1;
  localparam int LEN_USER_W        = 2;

  // Widest byte-enable bus the popcount helper handles (512-bit data).
  localparam int MAX_KEEP   = 64;
  localparam int POPCOUNT_W = 7;

  // Number of set byte enables in one beat.
  function automatic logic [POPCOUNT_W-1:0] popcount(input logic [MAX_KEEP-1:0] keep);
    logic [POPCOUNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_KEEP; i++) n = n + POPCOUNT_W'(keep[i]);
    return n;
  endfunction

endpackage

// File: rtl/axis_frame_len_fifo_if.sv
// Bundles the passive monitor tap and the length output stream.
// slave = the length FIFO block, master = whoever drives the monitor tap
// and consumes lengths.
interface axis_frame_len_fifo_if #(
  parameter int KEEP_WIDTH = 1,
  parameter int LEN_WIDTH  = 16
) ();
  import axis_frame_len_pkg::*;

  // monitored stream (observed only, never back-pressured)
  logic [KEEP_WIDTH-1:0] mon_axis_tkeep;
  logic                  mon_axis_tvalid;
  logic                  mon_axis_tready;
  logic                  mon_axis_tlast;
  logic                  mon_axis_tuser;

  // queued frame lengths
  logic [LEN_WIDTH-1:0]  m_axis_len_tdata;
  logic [LEN_USER_W-1:0] m_axis_len_tuser;
  logic                  m_axis_len_tvalid;
  logic                  m_axis_len_tready;

  modport slave (
    input  mon_axis_tkeep, mon_axis_tvalid, mon_axis_tready, mon_axis_tlast, mon_axis_tuser,
    input  m_axis_len_tready,
    output m_axis_len_tdata, m_axis_len_tuser, m_axis_len_tvalid
  );

  modport master (
    output mon_axis_tkeep, mon_axis_tvalid, mon_axis_tready, mon_axis_tlast, mon_axis_tuser,
    output m_axis_len_tready,
    input  m_axis_len_tdata, m_axis_len_tuser, m_axis_len_tvalid
  );

endinterface

// File: rtl/len_sync_fifo.sv
// Single-clock FIFO with a registered output stage.
// The output register counts toward DEPTH, so the RAM never holds more than
// DEPTH-1 entries. A write into an idle FIFO bypasses the RAM and lands in the
// output register directly, giving one-cycle write-to-valid latency.
module len_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_drop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      mem_cnt;
  logic             pop, full, push, mem_empty, load_out, bypass;

  // Handshake decode: a full FIFO still accepts a write when it pops the same cycle.
  always_comb begin
    pop       = rd_valid & rd_ready;
    full      = (count == FULL_CNT);
    push      = wr_en & (~full | pop);
    wr_drop   = wr_en & full & ~pop;
    mem_cnt   = count - {{AW{1'b0}}, rd_valid};
    mem_empty = (mem_cnt == '0);
    load_out  = ~rd_valid | pop;
    bypass    = push & mem_empty & load_out;
  end

  // RAM write port; data needs no reset.
  always_ff @(posedge clk) begin
    if (push && !bypass) mem[wr_ptr] <= wr_data;
  end

  // Pointers, output register refill and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push && !bypass) wr_ptr <= wr_ptr + 1'b1;
      if (load_out) begin
        if (!mem_empty) begin
          rd_data  <= mem[rd_ptr];
          rd_ptr   <= rd_ptr + 1'b1;
          rd_valid <= 1'b1;
        end else if (push) begin
          rd_data  <= wr_data;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_frame_len_fifo.sv
// Passive AXI-Stream frame-length monitor. Counts bytes of each transferred
// frame and queues {flags, length} entries for a downstream consumer.
module axis_frame_len_fifo
  import axis_frame_len_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int LEN_WIDTH      = 16,
  parameter int DEPTH          = 64,
  parameter int MAX_LEN        = 1522,
  parameter int DROP_BAD_FRAME = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_frame_len_fifo_if.slave   bus,
  output logic                   status_overflow,
  output logic                   status_bad_frame,
  output logic                   status_good_frame,
  output logic [$clog2(DEPTH):0] fill_level
);

  // Wide arithmetic so saturation and MAX_LEN compares never wrap.
  localparam int             SW              = LEN_WIDTH + 32;
  localparam int             EW              = LEN_USER_W + LEN_WIDTH;
  localparam int             FULL_BEAT_BYTES = (KEEP_WIDTH > 0) ? KEEP_WIDTH : DATA_WIDTH / 8;
  localparam logic [SW-1:0]  LEN_SAT         = SW'({LEN_WIDTH{1'b1}});
  localparam logic [SW-1:0]  MAX_LEN_W       = SW'(MAX_LEN);

  logic                  beat, last_beat, sat_now, oversize, drop_bad;
  logic [MAX_KEEP-1:0]   keep_ext;
  logic [SW-1:0]         beat_bytes, sum;
  logic [LEN_WIDTH-1:0]  acc, len_sum;
  logic                  acc_sat;
  logic [LEN_USER_W-1:0] wr_user;
  logic                  wr_en, wr_drop;
  logic [EW-1:0]         wr_data, rd_data;

  // Beat qualification, saturating byte accumulation and entry formation.
  always_comb begin
    beat       = bus.mon_axis_tvalid & bus.mon_axis_tready & ~rst;
    last_beat  = beat & bus.mon_axis_tlast;
    keep_ext   = MAX_KEEP'(bus.mon_axis_tkeep);
    beat_bytes = (KEEP_ENABLE != 0) ? SW'(popcount(keep_ext)) : SW'(FULL_BEAT_BYTES);
    sum        = SW'(acc) + beat_bytes;
    sat_now    = sum > LEN_SAT;
    len_sum    = sat_now ? {LEN_WIDTH{1'b1}} : sum[LEN_WIDTH-1:0];
    oversize   = SW'(len_sum) > MAX_LEN_W;
    wr_user                    = '0;
    wr_user[LEN_USER_BAD]      = bus.mon_axis_tuser;
    wr_user[LEN_USER_OVERSIZE] = acc_sat | sat_now | oversize;
    drop_bad   = (DROP_BAD_FRAME != 0) & bus.mon_axis_tuser;
    wr_en      = last_beat & ~drop_bad;
    wr_data    = {wr_user, len_sum};
  end

  // Running byte count of the frame in flight; cleared on its last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      acc_sat <= 1'b0;
    end else if (last_beat) begin
      acc     <= '0;
      acc_sat <= 1'b0;
    end else if (beat) begin
      acc     <= len_sum;
      acc_sat <= acc_sat | sat_now;
    end
  end

  // One-cycle status pulses, one cycle after the causing tlast beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      status_overflow   <= wr_drop;
      status_bad_frame  <= last_beat & bus.mon_axis_tuser;
      status_good_frame <= last_beat & ~bus.mon_axis_tuser;
    end
  end

  len_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_drop  (wr_drop),
    .rd_data  (rd_data),
    .rd_valid (bus.m_axis_len_tvalid),
    .rd_ready (bus.m_axis_len_tready),
    .count    (fill_level)
  );

  assign bus.m_axis_len_tdata = rd_data[LEN_WIDTH-1:0];
  assign bus.m_axis_len_tuser = rd_data[LEN_WIDTH +: LEN_USER_W];

endmodule

// File: tb/tb_axis_frame_len_fifo.sv
// Directed bench for axis_frame_len_fifo across three configurations:
//   w: 32-bit data with tkeep, depth 64
//   a: 8-bit data, depth 4
//   b: 8-bit data, 8-bit lengths, depth 8, bad frames dropped
module tb_axis_frame_len_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  axis_frame_len_fifo_if #(.KEEP_WIDTH(4), .LEN_WIDTH(16)) w_if ();
  axis_frame_len_fifo_if #(.KEEP_WIDTH(1), .LEN_WIDTH(16)) a_if ();
  axis_frame_len_fifo_if #(.KEEP_WIDTH(1), .LEN_WIDTH(8))  b_if ();

  logic w_ovf, w_bad, w_good; logic [6:0] w_fill;
  logic a_ovf, a_bad, a_good; logic [2:0] a_fill;
  logic b_ovf, b_bad, b_good; logic [3:0] b_fill;

  axis_frame_len_fifo #(.DATA_WIDTH(32)) u_w (
    .clk(clk), .rst(rst), .bus(w_if), .status_overflow(w_ovf),
    .status_bad_frame(w_bad), .status_good_frame(w_good), .fill_level(w_fill));

  axis_frame_len_fifo #(.DATA_WIDTH(8), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .bus(a_if), .status_overflow(a_ovf),
    .status_bad_frame(a_bad), .status_good_frame(a_good), .fill_level(a_fill));

  axis_frame_len_fifo #(.DATA_WIDTH(8), .LEN_WIDTH(8), .DEPTH(8), .DROP_BAD_FRAME(1)) u_b (
    .clk(clk), .rst(rst), .bus(b_if), .status_overflow(b_ovf),
    .status_bad_frame(b_bad), .status_good_frame(b_good), .fill_level(b_fill));

  // pulse counters, sampled mid-cycle
  int a_good_n = 0, a_ovf_n = 0, b_bad_n = 0, b_ovf_n = 0;
  always @(negedge clk) begin
    if (a_good === 1'b1) a_good_n++;
    if (a_ovf  === 1'b1) a_ovf_n++;
    if (b_bad  === 1'b1) b_bad_n++;
    if (b_ovf  === 1'b1) b_ovf_n++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic frame_a(input int n, input logic user);
    for (int i = 0; i < n; i++) begin
      a_if.mon_axis_tvalid = 1'b1; a_if.mon_axis_tready = 1'b1; a_if.mon_axis_tkeep = 1'b1;
      a_if.mon_axis_tlast = (i == n - 1); a_if.mon_axis_tuser = user;
      tick();
    end
    a_if.mon_axis_tvalid = 1'b0; a_if.mon_axis_tlast = 1'b0; a_if.mon_axis_tuser = 1'b0;
  endtask

  task automatic frame_b(input int n, input logic user);
    for (int i = 0; i < n; i++) begin
      b_if.mon_axis_tvalid = 1'b1; b_if.mon_axis_tready = 1'b1; b_if.mon_axis_tkeep = 1'b1;
      b_if.mon_axis_tlast = (i == n - 1); b_if.mon_axis_tuser = user;
      tick();
    end
    b_if.mon_axis_tvalid = 1'b0; b_if.mon_axis_tlast = 1'b0; b_if.mon_axis_tuser = 1'b0;
  endtask

  task automatic pop_a();
    a_if.m_axis_len_tready = 1'b1; tick(); a_if.m_axis_len_tready = 1'b0;
  endtask

  task automatic pop_b();
    b_if.m_axis_len_tready = 1'b1; tick(); b_if.m_axis_len_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    vectors++; if (w_if.m_axis_len_tvalid !== 1'b0) begin errors++; $display("FAIL reset_w_tvalid got %b want 0", w_if.m_axis_len_tvalid); end
    vectors++; if (a_if.m_axis_len_tvalid !== 1'b0) begin errors++; $display("FAIL reset_a_tvalid got %b want 0", a_if.m_axis_len_tvalid); end
    vectors++; if (b_if.m_axis_len_tvalid !== 1'b0) begin errors++; $display("FAIL reset_b_tvalid got %b want 0", b_if.m_axis_len_tvalid); end
    vectors++; if ({w_fill, a_fill, b_fill} !== 14'd0) begin errors++; $display("FAIL reset_fill got %0d/%0d/%0d want 0", w_fill, a_fill, b_fill); end
    vectors++; if ({w_ovf, w_bad, w_good, a_ovf, a_bad, a_good, b_ovf, b_bad, b_good} !== 9'd0) begin errors++; $display("FAIL reset_status got %b want 0", {w_ovf, w_bad, w_good, a_ovf, a_bad, a_good, b_ovf, b_bad, b_good}); end
    rst = 1'b0;
  endtask

  task automatic test_keep32();
    w_if.m_axis_len_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w_if.mon_axis_tvalid = 1'b1; w_if.mon_axis_tready = 1'b1; w_if.mon_axis_tkeep = 4'hF;
      w_if.mon_axis_tlast = 1'b0; w_if.mon_axis_tuser = 1'b0;
      tick();
    end
    w_if.mon_axis_tkeep = 4'b0011; w_if.mon_axis_tlast = 1'b1;
    vectors++; if (w_if.m_axis_len_tvalid !== 1'b0) begin errors++; $display("FAIL keep32_early_tvalid got %b want 0", w_if.m_axis_len_tvalid); end
    tick();
    w_if.mon_axis_tvalid = 1'b0; w_if.mon_axis_tlast = 1'b0;
    vectors++; if (w_if.m_axis_len_tvalid !== 1'b1) begin errors++; $display("FAIL keep32_tvalid got %b want 1", w_if.m_axis_len_tvalid); end
    vectors++; if (w_if.m_axis_len_tdata !== 16'd66) begin errors++; $display("FAIL keep32_len got %0d want 66", w_if.m_axis_len_tdata); end
    vectors++; if (w_if.m_axis_len_tuser !== 2'b00) begin errors++; $display("FAIL keep32_user got %b want 00", w_if.m_axis_len_tuser); end
    vectors++; if (w_good !== 1'b1) begin errors++; $display("FAIL keep32_good got %b want 1", w_good); end
    // second frame: 4 bytes, a stalled beat, a tkeep=0 beat, then 1 byte
    w_if.mon_axis_tvalid = 1'b1; w_if.mon_axis_tready = 1'b1; w_if.mon_axis_tkeep = 4'hF; tick();
    w_if.mon_axis_tready = 1'b0; tick();
    w_if.mon_axis_tready = 1'b1; w_if.mon_axis_tkeep = 4'h0; tick();
    w_if.mon_axis_tkeep = 4'b0100; w_if.mon_axis_tlast = 1'b1; tick();
    w_if.mon_axis_tvalid = 1'b0; w_if.mon_axis_tlast = 1'b0;
    vectors++; if (w_fill !== 7'd2) begin errors++; $display("FAIL keep32_fill2 got %0d want 2", w_fill); end
    vectors++; if (w_if.m_axis_len_tdata !== 16'd66) begin errors++; $display("FAIL keep32_hold got %0d want 66", w_if.m_axis_len_tdata); end
    w_if.m_axis_len_tready = 1'b1; tick();
    vectors++; if (w_if.m_axis_len_tdata !== 16'd5 || w_if.m_axis_len_tvalid !== 1'b1) begin errors++; $display("FAIL keep32_len2 got %0d/%b want 5/1", w_if.m_axis_len_tdata, w_if.m_axis_len_tvalid); end
    tick();
    vectors++; if (w_if.m_axis_len_tvalid !== 1'b0 || w_fill !== 7'd0) begin errors++; $display("FAIL keep32_drain got %b/%0d want 0/0", w_if.m_axis_len_tvalid, w_fill); end
    w_if.m_axis_len_tready = 1'b0;
  endtask

  task automatic test_oversize();
    int g0;
    g0 = a_good_n;
    a_if.m_axis_len_tready = 1'b0;
    frame_a(1600, 1'b0);
    vectors++; if (a_if.m_axis_len_tdata !== 16'd1600 || a_if.m_axis_len_tuser !== 2'b10) begin errors++; $display("FAIL over_1600 got %0d/%b want 1600/10", a_if.m_axis_len_tdata, a_if.m_axis_len_tuser); end
    tick();
    vectors++; if (a_good_n - g0 !== 1) begin errors++; $display("FAIL over_good_pulses got %0d want 1", a_good_n - g0); end
    pop_a();
    frame_a(1522, 1'b0);
    vectors++; if (a_if.m_axis_len_tdata !== 16'd1522 || a_if.m_axis_len_tuser !== 2'b00) begin errors++; $display("FAIL over_1522 got %0d/%b want 1522/00", a_if.m_axis_len_tdata, a_if.m_axis_len_tuser); end
    pop_a();
    frame_a(1523, 1'b0);
    vectors++; if (a_if.m_axis_len_tdata !== 16'd1523 || a_if.m_axis_len_tuser !== 2'b10) begin errors++; $display("FAIL over_1523 got %0d/%b want 1523/10", a_if.m_axis_len_tdata, a_if.m_axis_len_tuser); end
    pop_a();
    vectors++; if (a_fill !== 3'd0) begin errors++; $display("FAIL over_fill got %0d want 0", a_fill); end
  endtask

  task automatic test_saturate();
    b_if.m_axis_len_tready = 1'b0;
    frame_b(300, 1'b0);
    vectors++; if (b_if.m_axis_len_tdata !== 8'd255 || b_if.m_axis_len_tuser !== 2'b10) begin errors++; $display("FAIL sat_300 got %0d/%b want 255/10", b_if.m_axis_len_tdata, b_if.m_axis_len_tuser); end
    pop_b();
    frame_b(255, 1'b0);
    vectors++; if (b_if.m_axis_len_tdata !== 8'd255 || b_if.m_axis_len_tuser !== 2'b00) begin errors++; $display("FAIL sat_255 got %0d/%b want 255/00", b_if.m_axis_len_tdata, b_if.m_axis_len_tuser); end
    pop_b();
    frame_b(256, 1'b0);
    vectors++; if (b_if.m_axis_len_tdata !== 8'd255 || b_if.m_axis_len_tuser !== 2'b10) begin errors++; $display("FAIL sat_256 got %0d/%b want 255/10", b_if.m_axis_len_tdata, b_if.m_axis_len_tuser); end
    pop_b();
  endtask

  task automatic test_overflow();
    int o0;
    o0 = a_ovf_n;
    a_if.m_axis_len_tready = 1'b0;
    for (int k = 0; k < 6; k++) frame_a(10 + k, 1'b0);
    tick();
    vectors++; if (a_fill !== 3'd4) begin errors++; $display("FAIL ovf_fill got %0d want 4", a_fill); end
    vectors++; if (a_ovf_n - o0 !== 2) begin errors++; $display("FAIL ovf_pulses got %0d want 2", a_ovf_n - o0); end
    a_if.m_axis_len_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (a_if.m_axis_len_tvalid !== 1'b1 || a_if.m_axis_len_tdata !== 16'(10 + k)) begin errors++; $display("FAIL ovf_order%0d got %b/%0d want 1/%0d", k, a_if.m_axis_len_tvalid, a_if.m_axis_len_tdata, 10 + k); end
      tick();
    end
    vectors++; if (a_if.m_axis_len_tvalid !== 1'b0 || a_fill !== 3'd0) begin errors++; $display("FAIL ovf_drain got %b/%0d want 0/0", a_if.m_axis_len_tvalid, a_fill); end
    a_if.m_axis_len_tready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int o0;
    a_if.m_axis_len_tready = 1'b0;
    for (int k = 2; k <= 5; k++) frame_a(k, 1'b0);
    vectors++; if (a_fill !== 3'd4) begin errors++; $display("FAIL b2b_fill got %0d want 4", a_fill); end
    o0 = a_ovf_n;
    a_if.m_axis_len_tready = 1'b1;
    frame_a(1, 1'b0);
    vectors++; if (a_fill !== 3'd4 || a_if.m_axis_len_tdata !== 16'd3) begin errors++; $display("FAIL b2b_pushpop got %0d/%0d want 4/3", a_fill, a_if.m_axis_len_tdata); end
    tick();
    vectors++; if (a_if.m_axis_len_tdata !== 16'd4) begin errors++; $display("FAIL b2b_q1 got %0d want 4", a_if.m_axis_len_tdata); end
    tick();
    vectors++; if (a_if.m_axis_len_tdata !== 16'd5) begin errors++; $display("FAIL b2b_q2 got %0d want 5", a_if.m_axis_len_tdata); end
    tick();
    vectors++; if (a_if.m_axis_len_tdata !== 16'd1 || a_if.m_axis_len_tvalid !== 1'b1) begin errors++; $display("FAIL b2b_q3 got %0d/%b want 1/1", a_if.m_axis_len_tdata, a_if.m_axis_len_tvalid); end
    tick();
    vectors++; if (a_if.m_axis_len_tvalid !== 1'b0 || a_ovf_n - o0 !== 0) begin errors++; $display("FAIL b2b_end got %b/%0d want 0/0", a_if.m_axis_len_tvalid, a_ovf_n - o0); end
    a_if.m_axis_len_tready = 1'b0;
  endtask

  task automatic test_drop_bad();
    int bb0, bo0;
    bb0 = b_bad_n; bo0 = b_ovf_n;
    b_if.m_axis_len_tready = 1'b0;
    frame_b(64, 1'b1);
    vectors++; if (b_bad !== 1'b1 || b_good !== 1'b0) begin errors++; $display("FAIL drop_bad_pulse got %b/%b want 1/0", b_bad, b_good); end
    vectors++; if (b_if.m_axis_len_tvalid !== 1'b0 || b_fill !== 4'd0) begin errors++; $display("FAIL drop_not_queued got %b/%0d want 0/0", b_if.m_axis_len_tvalid, b_fill); end
    frame_b(64, 1'b0);
    vectors++; if (b_if.m_axis_len_tvalid !== 1'b1 || b_if.m_axis_len_tdata !== 8'd64 || b_if.m_axis_len_tuser !== 2'b00) begin errors++; $display("FAIL drop_good got %b/%0d/%b want 1/64/00", b_if.m_axis_len_tvalid, b_if.m_axis_len_tdata, b_if.m_axis_len_tuser); end
    frame_b(64, 1'b1);
    frame_b(64, 1'b0);
    tick();
    vectors++; if (b_fill !== 4'd2) begin errors++; $display("FAIL drop_fill got %0d want 2", b_fill); end
    vectors++; if (b_bad_n - bb0 !== 2 || b_ovf_n - bo0 !== 0) begin errors++; $display("FAIL drop_counts got bad %0d ovf %0d want 2/0", b_bad_n - bb0, b_ovf_n - bo0); end
    pop_b();
    vectors++; if (b_if.m_axis_len_tvalid !== 1'b1 || b_if.m_axis_len_tdata !== 8'd64 || b_if.m_axis_len_tuser !== 2'b00) begin errors++; $display("FAIL drop_second got %b/%0d/%b want 1/64/00", b_if.m_axis_len_tvalid, b_if.m_axis_len_tdata, b_if.m_axis_len_tuser); end
    pop_b();
    vectors++; if (b_if.m_axis_len_tvalid !== 1'b0 || b_fill !== 4'd0) begin errors++; $display("FAIL drop_drain got %b/%0d want 0/0", b_if.m_axis_len_tvalid, b_fill); end
  endtask

  task automatic test_reset_mid();
    a_if.m_axis_len_tready = 1'b0;
    frame_a(7, 1'b0);
    vectors++; if (a_fill !== 3'd1) begin errors++; $display("FAIL rstmid_pre_fill got %0d want 1", a_fill); end
    for (int i = 0; i < 10; i++) begin
      a_if.mon_axis_tvalid = 1'b1; a_if.mon_axis_tready = 1'b1; a_if.mon_axis_tkeep = 1'b1;
      a_if.mon_axis_tlast = 1'b0; a_if.mon_axis_tuser = 1'b0;
      tick();
    end
    rst = 1'b1;
    tick();
    vectors++; if (a_if.m_axis_len_tvalid !== 1'b0 || a_fill !== 3'd0) begin errors++; $display("FAIL rstmid_in_reset got %b/%0d want 0/0", a_if.m_axis_len_tvalid, a_fill); end
    tick();
    rst = 1'b0;
    frame_a(5, 1'b0);
    vectors++; if (a_if.m_axis_len_tvalid !== 1'b1 || a_if.m_axis_len_tdata !== 16'd5 || a_fill !== 3'd1) begin errors++; $display("FAIL rstmid_len got %b/%0d/%0d want 1/5/1", a_if.m_axis_len_tvalid, a_if.m_axis_len_tdata, a_fill); end
    pop_a();
  endtask

  initial begin
    w_if.mon_axis_tvalid = 1'b0; w_if.mon_axis_tready = 1'b0; w_if.mon_axis_tkeep = '0;
    w_if.mon_axis_tlast = 1'b0; w_if.mon_axis_tuser = 1'b0; w_if.m_axis_len_tready = 1'b0;
    a_if.mon_axis_tvalid = 1'b0; a_if.mon_axis_tready = 1'b0; a_if.mon_axis_tkeep = '0;
    a_if.mon_axis_tlast = 1'b0; a_if.mon_axis_tuser = 1'b0; a_if.m_axis_len_tready = 1'b0;
    b_if.mon_axis_tvalid = 1'b0; b_if.mon_axis_tready = 1'b0; b_if.mon_axis_tkeep = '0;
    b_if.mon_axis_tlast = 1'b0; b_if.mon_axis_tuser = 1'b0; b_if.m_axis_len_tready = 1'b0;
    test_reset();
    test_keep32();
    test_oversize();
    test_saturate();
    test_overflow();
    test_back_to_back();
    test_drop_bad();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
